// File: rtl/commit_store_buffer.sv
// commit_store_buffer: eight-entry in-order store buffer. Entries are allocated
// at rename, filled by the store unit, committed in order by the commit stage
// and drained to data memory one per cycle from the head.
module commit_store_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          recover,
  input  logic          stall,
  input  logic          alloc_req1,
  input  logic          alloc_req2,
  output logic          alloc_ok,
  output logic [2:0]    alloc_num1,
  output logic [2:0]    alloc_num2,
  input  logic          fill_en,
  input  logic [2:0]    fill_num,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  input  logic [3:0]    fill_be,
  input  logic          write1,
  input  logic          write2,
  input  logic [2:0]    sbnum1,
  input  logic [2:0]    sbnum2,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  output logic          sb_empty,
  output logic          sb_full,
  output logic          sb_err
);

  localparam int unsigned IW = 3;
  localparam int unsigned PW = 4;
  localparam int unsigned BW = 4;

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_ALLOC  = 2'd1;
  localparam logic [1:0] ST_FILLED = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  logic [1:0]    state_q [DEPTH];
  logic [1:0]    state_d [DEPTH];
  logic [AW-1:0] addr_q  [DEPTH];
  logic [AW-1:0] addr_d  [DEPTH];
  logic [DW-1:0] data_q  [DEPTH];
  logic [DW-1:0] data_d  [DEPTH];
  logic [BW-1:0] be_q    [DEPTH];
  logic [BW-1:0] be_d    [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] ctail_q, ctail_d;
  logic          sb_err_q, sb_err_d;

  logic [PW-1:0] occ;
  logic [PW-1:0] free_cnt;
  logic [PW-1:0] req_cnt;
  logic [IW-1:0] hidx;

  // Grant logic, head presentation and status flags from registered pointers
  always_comb begin
    occ        = tail_q - head_q;
    free_cnt   = PW'(DEPTH) - occ;
    req_cnt    = PW'(alloc_req1) + PW'(alloc_req2);
    alloc_ok   = (req_cnt <= free_cnt) && !recover && !rst;
    alloc_num1 = tail_q[IW-1:0];
    alloc_num2 = IW'(tail_q + PW'(alloc_req1));
    hidx       = head_q[IW-1:0];
    mem_req    = (state_q[hidx] == ST_COMMIT);
    mem_addr   = addr_q[hidx];
    mem_data   = data_q[hidx];
    mem_be     = be_q[hidx];
    sb_empty   = (head_q == tail_q);
    sb_full    = (free_cnt < PW'(2));
    sb_err     = sb_err_q;
  end

  // Next state: commits, fill, allocation, drain, then recovery squash
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      state_d[IW'(i)] = state_q[IW'(i)];
      addr_d[IW'(i)]  = addr_q[IW'(i)];
      data_d[IW'(i)]  = data_q[IW'(i)];
      be_d[IW'(i)]    = be_q[IW'(i)];
    end
    head_d   = head_q;
    tail_d   = tail_q;
    ctail_d  = ctail_q;
    sb_err_d = sb_err_q;

    // In-order commit; slot 2 is checked against ctail after slot 1
    if (!stall) begin
      if (write1) begin
        if ((sbnum1 == ctail_d[IW-1:0]) && (state_q[sbnum1] == ST_FILLED)) begin
          state_d[sbnum1] = ST_COMMIT;
          ctail_d         = ctail_d + PW'(1);
        end else begin
          sb_err_d = 1'b1;
        end
      end
      if (write2) begin
        if ((sbnum2 == ctail_d[IW-1:0]) && (state_q[sbnum2] == ST_FILLED)) begin
          state_d[sbnum2] = ST_COMMIT;
          ctail_d         = ctail_d + PW'(1);
        end else begin
          sb_err_d = 1'b1;
        end
      end
    end

    // Fill is dropped silently during recovery
    if (fill_en && !recover) begin
      if (state_q[fill_num] == ST_ALLOC) begin
        state_d[fill_num] = ST_FILLED;
        addr_d[fill_num]  = fill_addr;
        data_d[fill_num]  = fill_data;
        be_d[fill_num]    = fill_be;
      end else begin
        sb_err_d = 1'b1;
      end
    end

    if (alloc_ok) begin
      if (alloc_req1) state_d[alloc_num1] = ST_ALLOC;
      if (alloc_req2) state_d[alloc_num2] = ST_ALLOC;
      tail_d = tail_q + req_cnt;
    end

    if (mem_req && mem_ack) begin
      state_d[hidx] = ST_FREE;
      head_d        = head_q + PW'(1);
    end

    // Squash everything younger than the committed region
    if (recover) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((state_d[IW'(i)] == ST_ALLOC) || (state_d[IW'(i)] == ST_FILLED)) begin
          state_d[IW'(i)] = ST_FREE;
        end
      end
      tail_d = ctail_d;
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      ctail_q  <= '0;
      sb_err_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        state_q[IW'(i)] <= ST_FREE;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      ctail_q  <= ctail_d;
      sb_err_q <= sb_err_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        state_q[IW'(i)] <= state_d[IW'(i)];
      end
    end
  end

  // Entry payload; only meaningful while the entry state says so
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      addr_q[IW'(i)] <= addr_d[IW'(i)];
      data_q[IW'(i)] <= data_d[IW'(i)];
      be_q[IW'(i)]   <= be_d[IW'(i)];
    end
  end

endmodule
